sram_arbiter: RTL

//  Owns the single shared 16-bit SRAM and sequences every access to it. It arbitrates three requesters:
//  - video fetch: fixed slot, absolute priority;
//  - debug host (JTAG): hold/hlda handshake;
//  - CPU: req/ack handshake.

---
 rtl/bk_mem_pkg.sv | 29 ++
 rtl/sram_pin_mux.sv | 46 ++++
 rtl/sram_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/bk_mem_pkg.sv
// Shared types and sizing for the SRAM arbiter: FSM state encoding, default
// bus widths and the access-length bound applied to ACC_CYC.
package bk_mem_pkg;

   localparam int ADDR_W_DEF  = 18;
   localparam int DATA_W_DEF  = 16;
   localparam int ACC_CYC_MAX = 7;
   localparam int CNT_W       = 3;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CPU_ACC  = 2'd1,
      HOST_ACC = 2'd2,
      ACK      = 2'd3
   } arb_state_t;

   // Out-of-range access lengths are pulled into 1..ACC_CYC_MAX so the
   // 3-bit cycle counter can always reach its terminal value.
   function automatic int acc_cyc_clamp(input int n);
      if (n < 1) begin
         return 1;
      end
      if (n > ACC_CYC_MAX) begin
         return ACC_CYC_MAX;
      end
      return n;
   endfunction

endpackage

// File: rtl/sram_pin_mux.sv
// SRAM pin driver: passes the registered access strobes through, except in a
// video slot cycle, where the video read takes the pins combinationally.
module sram_pin_mux
   import bk_mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              i_vid_slot,
   input  logic [ADDR_W-1:0] i_vid_addr,
   input  logic [ADDR_W-1:0] i_acc_addr,
   input  logic [DATA_W-1:0] i_acc_wdata,
   input  logic              i_acc_oe_n,
   input  logic              i_acc_we_n,
   input  logic              i_acc_lb_n,
   input  logic              i_acc_ub_n,
   input  logic              i_acc_dq_oe,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic [DATA_W-1:0] o_sram_dq_o,
   output logic              o_sram_dq_oe,
   output logic              o_sram_oe_n,
   output logic              o_sram_we_n,
   output logic              o_sram_lb_n,
   output logic              o_sram_ub_n
);

   always_comb begin
      o_sram_addr  = i_acc_addr;
      o_sram_dq_o  = i_acc_wdata;
      o_sram_dq_oe = i_acc_dq_oe;
      o_sram_oe_n  = i_acc_oe_n;
      o_sram_we_n  = i_acc_we_n;
      o_sram_lb_n  = i_acc_lb_n;
      o_sram_ub_n  = i_acc_ub_n;
      // Video fetch is a full-word read and must never collide with a write drive.
      if (i_vid_slot) begin
         o_sram_addr  = i_vid_addr;
         o_sram_dq_oe = 1'b0;
         o_sram_oe_n  = 1'b0;
         o_sram_we_n  = 1'b1;
         o_sram_lb_n  = 1'b0;
         o_sram_ub_n  = 1'b0;
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Single owner of the shared 16-bit SRAM: video slots pre-empt everything,
// the debug host gets the bus via hold/hlda, the CPU uses req/ack.
module sram_arbiter
   import bk_mem_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ACC_CYC = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [1:0]        cpu_be,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   input  logic              host_hold,
   output logic              host_hlda,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_ack,
   input  logic              vid_slot,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic [DATA_W-1:0] vid_data,
   output logic              vid_valid,
   output logic [ADDR_W-1:0] sram_addr,
   input  logic [DATA_W-1:0] sram_dq_i,
   output logic [DATA_W-1:0] sram_dq_o,
   output logic              sram_dq_oe,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic              sram_lb_n,
   output logic              sram_ub_n
);

   localparam int              ACC_N  = acc_cyc_clamp(ACC_CYC);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(ACC_N - 1);

   arb_state_t        r_state;
   arb_state_t        w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_host_own;
   logic              r_we;
   logic              r_hlda;
   logic              r_cpu_ack;
   logic              r_host_ack;
   logic [DATA_W-1:0] r_cpu_rdata;
   logic [DATA_W-1:0] r_host_rdata;
   logic [DATA_W-1:0] r_vid_data;
   logic              r_vid_valid;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_oe_n;
   logic              r_we_n;
   logic              r_lb_n;
   logic              r_ub_n;
   logic              r_dq_oe;

   logic              w_acc;
   logic              w_last;
   logic              w_host_grant;
   logic              w_cpu_grant;

   always_comb begin
      w_acc        = (r_state == CPU_ACC) || (r_state == HOST_ACC);
      // A video slot stalls the access: that cycle never counts toward ACC_CYC.
      w_last       = w_acc && !vid_slot && (r_cnt == LAST);
      w_host_grant = r_hlda && host_req;
      w_cpu_grant  = !r_hlda && !host_hold && cpu_req;
      w_next       = r_state;
      case (r_state)
         IDLE: begin
            if (w_host_grant) begin
               w_next = HOST_ACC;
            end else if (w_cpu_grant) begin
               w_next = CPU_ACC;
            end
         end
         CPU_ACC, HOST_ACC: begin
            if (w_last) begin
               w_next = ACK;
            end
         end
         ACK:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_host_own   <= 1'b0;
         r_we         <= 1'b0;
         r_hlda       <= 1'b0;
         r_cpu_ack    <= 1'b0;
         r_host_ack   <= 1'b0;
         r_cpu_rdata  <= '0;
         r_host_rdata <= '0;
         r_vid_data   <= '0;
         r_vid_valid  <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_oe_n       <= 1'b1;
         r_we_n       <= 1'b1;
         r_lb_n       <= 1'b1;
         r_ub_n       <= 1'b1;
         r_dq_oe      <= 1'b0;
      end else begin
         r_state     <= w_next;
         // hlda only changes between accesses, so ownership never flips mid-transfer.
         if (w_next == IDLE) begin
            r_hlda <= host_hold;
         end
         r_cpu_ack   <= w_last && !r_host_own;
         r_host_ack  <= w_last && r_host_own;
         r_vid_valid <= vid_slot;
         if (vid_slot) begin
            r_vid_data <= sram_dq_i;
         end
         if (w_acc && !vid_slot) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
         end

         if (w_last) begin
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_lb_n  <= 1'b1;
            r_ub_n  <= 1'b1;
            r_dq_oe <= 1'b0;
            if (!r_we) begin
               if (r_host_own) begin
                  r_host_rdata <= sram_dq_i;
               end else begin
                  r_cpu_rdata <= sram_dq_i;
               end
            end
         end else if (r_state == IDLE && w_next == HOST_ACC) begin
            r_host_own <= 1'b1;
            r_we       <= host_we;
            r_addr     <= host_addr;
            r_wdata    <= host_wdata;
            r_oe_n     <= host_we;
            r_we_n     <= !host_we;
            r_lb_n     <= 1'b0;
            r_ub_n     <= 1'b0;
            r_dq_oe    <= host_we;
         end else if (r_state == IDLE && w_next == CPU_ACC) begin
            r_host_own <= 1'b0;
            r_we       <= cpu_we;
            r_addr     <= cpu_addr;
            r_wdata    <= cpu_wdata;
            r_oe_n     <= cpu_we;
            // A write with no lanes enabled still runs its cycles but never strobes.
            r_we_n     <= !(cpu_we && (cpu_be != 2'b00));
            r_lb_n     <= cpu_we ? !cpu_be[0] : 1'b0;
            r_ub_n     <= cpu_we ? !cpu_be[1] : 1'b0;
            r_dq_oe    <= cpu_we;
         end
      end
   end

   assign cpu_rdata  = r_cpu_rdata;
   assign cpu_ack    = r_cpu_ack;
   assign host_hlda  = r_hlda;
   assign host_rdata = r_host_rdata;
   assign host_ack   = r_host_ack;
   assign vid_data   = r_vid_data;
   assign vid_valid  = r_vid_valid;

   sram_pin_mux #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_pin_mux (
      .i_vid_slot   (vid_slot),
      .i_vid_addr   (vid_addr),
      .i_acc_addr   (r_addr),
      .i_acc_wdata  (r_wdata),
      .i_acc_oe_n   (r_oe_n),
      .i_acc_we_n   (r_we_n),
      .i_acc_lb_n   (r_lb_n),
      .i_acc_ub_n   (r_ub_n),
      .i_acc_dq_oe  (r_dq_oe),
      .o_sram_addr  (sram_addr),
      .o_sram_dq_o  (sram_dq_o),
      .o_sram_dq_oe (sram_dq_oe),
      .o_sram_oe_n  (sram_oe_n),
      .o_sram_we_n  (sram_we_n),
      .o_sram_lb_n  (sram_lb_n),
      .o_sram_ub_n  (sram_ub_n)
   );

endmodule
